// File: rtl/sha2_block_engine.sv
//==============================================================================
// Module      : sha2_block_engine
// Description : SHA-256/224 block compression engine, UNROLL rounds per clock,
//               with internal message schedule, K table and hash chaining.
//               Optional SHA-224 support when SHA2_SHA224_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module sha2_block_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         mode,
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         busy
);

    // Word i of a working/hash set lives at index i (a = 0 ... h = 7).
    typedef logic [7:0][31:0] t_words;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } t_state;

    localparam t_words C_IV256 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

`ifdef SHA2_SHA224_EN
    localparam t_words C_IV224 = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
    };
`endif

    // K[t] sits at index 63-t.
    localparam logic [63:0][31:0] C_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] C_LAST_T = 6'(64 - UNROLL);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic t_words round_step(input t_words s, input logic [31:0] k,
                                          input logic [31:0] w);
        logic [31:0] t1;
        logic [31:0] t2;
        t_words      n;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
                  + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        n[0] = t1 + t2;
        n[1] = s[0];
        n[2] = s[1];
        n[3] = s[2];
        n[4] = s[3] + t1;
        n[5] = s[4];
        n[6] = s[5];
        n[7] = s[6];
        return n;
    endfunction

    t_state             r_state;
    t_state             w_state_nxt;
    t_words             r_h;
    t_words             r_wv;
    logic [15:0][31:0]  r_win;
    logic [5:0]         r_round;
    logic [255:0]       r_digest;
    t_words             w_iv;
    t_words             w_st;
    t_words             w_h_new;
    logic [255:0]       w_dig_new;
    logic [31:0]        w_ext [16+UNROLL];
    logic [15:0][31:0]  w_win_nxt;

`ifdef SHA2_SHA224_EN
    logic               r_mode;

    always_comb begin
        w_iv = mode ? C_IV224 : C_IV256;
    end
`else
    logic               w_unused;

    assign w_unused = mode;

    always_comb begin
        w_iv = C_IV256;
    end
`endif

    // Schedule: window holds W[t..t+15]; extend by UNROLL words, then slide.
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_ext[j] = r_win[j];
        end
        for (int u = 0; u < UNROLL; u++) begin
            w_ext[16+u] = ssig1(w_ext[14+u]) + w_ext[9+u] + ssig0(w_ext[1+u]) + w_ext[u];
        end
        for (int j = 0; j < 16; j++) begin
            w_win_nxt[j] = w_ext[j+UNROLL];
        end
    end

    always_comb begin
        w_st = r_wv;
        for (int u = 0; u < UNROLL; u++) begin
            w_st = round_step(w_st, C_K[6'd63 - (r_round + 6'(u))], w_ext[u]);
        end
    end

    always_comb begin
        w_h_new   = '0;
        w_dig_new = '0;
        for (int i = 0; i < 8; i++) begin
            w_h_new[i]                = r_h[i] + r_wv[i];
            w_dig_new[255-32*i -: 32] = w_h_new[i];
        end
`ifdef SHA2_SHA224_EN
        if (r_mode) begin
            w_dig_new[31:0] = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        blk_ready    = 1'b0;
        busy         = 1'b1;
        digest_valid = 1'b0;
        digest       = r_digest;
        case (r_state)
            ST_IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
                if (blk_valid) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (r_round == C_LAST_T) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                digest_valid = 1'b1;
                digest       = w_dig_new;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h      <= C_IV256;
            r_wv     <= '0;
            r_win    <= '0;
            r_round  <= '0;
            r_digest <= '0;
`ifdef SHA2_SHA224_EN
            r_mode   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        for (int j = 0; j < 16; j++) begin
                            r_win[j] <= blk_data[511-32*j -: 32];
                        end
                        r_round <= '0;
                        if (blk_first) begin
                            r_h  <= w_iv;
                            r_wv <= w_iv;
`ifdef SHA2_SHA224_EN
                            r_mode <= mode;
`endif
                        end else begin
                            r_wv <= r_h;
                        end
                    end
                end
                ST_ROUND: begin
                    r_wv    <= w_st;
                    r_win   <= w_win_nxt;
                    r_round <= r_round + 6'(UNROLL);
                end
                ST_FINAL: begin
                    r_h      <= w_h_new;
                    r_digest <= w_dig_new;
                end
                default: begin
                    r_round <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha2_block_engine.sv
//==============================================================================
// Module      : tb_sha2_block_engine
// Description : Bench for sha2_block_engine at UNROLL = 1, 2 and 4 against a
//               plain SHA-2 reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sha2_block_engine;

    localparam int N = 3;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224  = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {{15{32'h0}}, 32'h000001c0};

    logic         clk = 1'b0;
    logic         reset;
    logic         bv [N];
    logic [511:0] bd [N];
    logic         bf [N];
    logic         bm [N];
    logic         br [N];
    logic         dv [N];
    logic [255:0] dg [N];
    logic         bz [N];

    int total = 0;
    int bad   = 0;

    logic [255:0] ref_h [N];
    logic         ref_m [N];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            sha2_block_engine #(.UNROLL(1 << gi)) u_dut (
                .clk          (clk),
                .reset        (reset),
                .blk_valid    (bv[gi]),
                .blk_ready    (br[gi]),
                .blk_data     (bd[gi]),
                .blk_first    (bf[gi]),
                .mode         (bm[gi]),
                .digest_valid (dv[gi]),
                .digest       (dg[gi]),
                .busy         (bz[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 compression of one block onto a hash value.
    function automatic logic [255:0] ref_compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  hh [8];
        logic [31:0]  v [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) hh[i] = hv[255-32*i -: 32];
        v = hh;
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hh[i] + v[i];
        return res;
    endfunction

    task automatic model_block(input int s, input logic [511:0] blk, input logic first, input logic md);
        logic m_eff;
`ifdef SHA2_SHA224_EN
        m_eff = md;
`else
        m_eff = 1'b0 & md;
`endif
        if (first) begin
            ref_m[s] = m_eff;
            ref_h[s] = m_eff ? IV224 : IV256;
        end
        ref_h[s] = ref_compress(ref_h[s], blk);
    endtask

    function automatic logic [255:0] exp_digest(input int s);
        return ref_m[s] ? {ref_h[s][255:32], 32'h0} : ref_h[s];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            ref_h[i] = IV256;
            ref_m[i] = 1'b0;
        end
    endtask

    task automatic wait_ready(input int s, input string tag);
        int n = 0;
        while (!br[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 256'(br[s]), 256'(1));
    endtask

    // Entered at the negedge of cycle 1 after the handshake.
    task automatic wait_digest(input int s, input string tag);
        int   n    = 1;
        logic viol = 1'b0;
        while (!dv[s] && n < 200) begin
            if (br[s] || !bz[s]) viol = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 256'(n), 256'(64 / (1 << s) + 1));
        check({tag, "_digest"}, dg[s], exp_digest(s));
        check({tag, "_busy"}, 256'(viol), 256'(0));
        @(negedge clk);
        check({tag, "_hold"}, dg[s], exp_digest(s));
        check({tag, "_idle"}, 256'({dv[s], br[s], bz[s]}), 256'(3'b010));
    endtask

    task automatic do_block(input int s, input logic [511:0] blk, input logic first,
                            input logic md, input string tag);
        @(negedge clk);
        bv[s] = 1'b1; bd[s] = blk; bf[s] = first; bm[s] = md;
        wait_ready(s, tag);
        model_block(s, blk, first, md);
        @(negedge clk);
        bv[s] = 1'b0; bd[s] = rand512(); bf[s] = 1'($urandom); bm[s] = 1'($urandom);
        wait_digest(s, tag);
    endtask

    task automatic two_block(input int s);
        int           n    = 1;
        int           dvat = -1;
        logic         viol = 1'b0;
        logic [255:0] mid;
        @(negedge clk);
        bv[s] = 1'b1; bd[s] = BLK_TWO1; bf[s] = 1'b1; bm[s] = 1'b0;
        wait_ready(s, "b2b_first");
        model_block(s, BLK_TWO1, 1'b1, 1'b0);
        mid = exp_digest(s);
        @(negedge clk);
        bd[s] = BLK_TWO2; bf[s] = 1'b0; bm[s] = 1'b1;
        while (!br[s] && n < 200) begin
            if (!bz[s]) viol = 1'b1;
            if (dv[s] && dvat < 0) begin
                dvat = n;
                check("b2b_mid_digest", dg[s], mid);
            end
            @(negedge clk);
            n++;
        end
        check("b2b_second_hs", 256'(n), 256'(64 / (1 << s) + 2));
        check("b2b_first_dv", 256'(dvat), 256'(64 / (1 << s) + 1));
        check("b2b_ready_low", 256'(viol), 256'(0));
        model_block(s, BLK_TWO2, 1'b0, 1'b1);
        @(negedge clk);
        bv[s] = 1'b0; bd[s] = rand512();
        wait_digest(s, "b2b");
        check("b2b_const", dg[s], TWO);
    endtask

    task automatic reset_mid(input int s);
        int pulses = 0;
        @(negedge clk);
        bv[s] = 1'b1; bd[s] = rand512(); bf[s] = 1'b1; bm[s] = 1'b0;
        wait_ready(s, "abort");
        @(negedge clk);
        bv[s] = 1'b0;
        for (int i = 0; i < 20 / (1 << s); i++) begin
            if (dv[s]) pulses++;
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        if (dv[s]) pulses++;
        @(negedge clk);
        check("abort_ctl", 256'({br[s], dv[s], bz[s]}), 256'(3'b100));
        check("abort_digest", dg[s], 256'(0));
        reset = 1'b0;
        reset_model();
        @(negedge clk);
        if (dv[s]) pulses++;
        check("abort_pulse", 256'(pulses), 256'(0));
        do_block(s, BLK_ABC, 1'b0, 1'b1, "abc_chain");
        check("abc_chain_const", dg[s], ABC256);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            bv[i] = 1'b0; bd[i] = '0; bf[i] = 1'b0; bm[i] = 1'b0;
        end
        reset_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < N; s++) begin
            check("reset_ctl", 256'({br[s], dv[s], bz[s]}), 256'(3'b100));
            check("reset_digest", dg[s], 256'(0));
        end

        for (int s = 0; s < N; s++) begin
            do_block(s, BLK_ABC, 1'b1, 1'b0, "abc");
            check("abc_const", dg[s], ABC256);
            do_block(s, BLK_EMPTY, 1'b1, 1'b0, "empty");
            check("empty_const", dg[s], EMPTY);
            two_block(s);
            do_block(s, BLK_ABC, 1'b1, 1'b1, "abc_mode1");
`ifdef SHA2_SHA224_EN
            check("abc224_const", dg[s], ABC224);
`else
            check("abc_mode1_const", dg[s], ABC256);
`endif
            reset_mid(s);
            for (int m = 0; m < 3; m++) begin
                int   nb = $urandom_range(3, 1);
                logic md = 1'($urandom);
                for (int b = 0; b < nb; b++) begin
                    do_block(s, rand512(), b == 0, (b == 0) ? md : 1'($urandom), "random");
                    repeat ($urandom_range(2, 0)) @(negedge clk);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sha2_block_engine.md
# sha2_block_engine

Parametrised SHA-2 compression engine and successor to the single-round SHA-256 compression block. It accepts whole 512-bit message blocks over a valid/ready handshake, expands the message schedule internally and holds the 64-entry K table. It executes UNROLL rounds per clock and chains the hash state across multi-block messages. It sits between the padding/block-assembly logic and the digest consumer; no external scheduler or K block is needed.

## Interface
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 4 (must divide 64)
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- blk_valid  in  1  blk_data/blk_first/mode valid
- blk_ready  out  1  engine can accept a block; high only in IDLE
- blk_data  in  512  message block; W0 = [511:480], W15 = [31:0]
- blk_first  in  1  1 = first block of a message (load IV); 0 = chain from current H
- mode  in  1  0 = SHA-256, 1 = SHA-224; sampled only when blk_first=1
- digest_valid  out  1  one-cycle pulse: digest updated
- digest  out  256  H0..H7 concatenated, H0 at [255:224]
- busy  out  1  high in ROUND and FINAL

## Operation
- FSM states: IDLE, ROUND, FINAL.
- IDLE: blk_ready=1. A handshake (blk_valid & blk_ready at the clock edge) does the following:
  - Loads the 16-word W window from blk_data.
  - Loads a..h from the mode IV if blk_first=1, otherwise from the current H.
  - Latches mode when blk_first=1 and copies the IV into H.
  - Clears the round counter and goes to ROUND.
- ROUND: each cycle executes UNROLL consecutive rounds t..t+UNROLL-1.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Schedule for t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]; σ0 = ROTR7^ROTR18^SHR3, σ1 = ROTR17^ROTR19^SHR10. The window shifts by UNROLL words per cycle.
  - The counter advances by UNROLL. After round 63 the FSM goes to FINAL.
- FINAL: Hi <= Hi + working var i (all eight, mod 2^32). digest_valid=1 this cycle and digest shows the new H. Next state is IDLE.
- All additions are 32-bit modulo 2^32; carries are discarded.
- Digest word layout:
  - SHA-256: digest = H0..H7.
  - SHA-224: digest[255:32] = H0..H6 and digest[31:0] = 0.
- digest holds its value until the next FINAL.
- blk_first=0 after reset with no prior first block: chains from the SHA-256 IV (H resets to the SHA-256 IV, latched mode resets to 0).
- blk_data, blk_first and mode are ignored outside the handshake cycle and may change freely afterwards.
- blk_valid while busy: no effect. The block is accepted only when the engine returns to IDLE.

## Timing
- Reset values: blk_ready=1, digest_valid=0, busy=0, digest=0. FSM=IDLE; H=SHA-256 IV; latched mode=0.
- Reset mid-block aborts the computation; H reverts to the SHA-256 IV.
- Handshake at edge E0. Round edges are E0+1 .. E0+64/UNROLL. The FINAL state is entered at edge E0+64/UNROLL.
- digest_valid is high for the one cycle following edge E0+64/UNROLL. The H update is registered at edge E0+64/UNROLL+1.
- blk_ready rises when the FSM returns to IDLE. The earliest next handshake is edge E0+64/UNROLL+2, giving a throughput of one block per 64/UNROLL+2 cycles.
- Handshake-to-digest_valid latency: 65 cycles for UNROLL=1, 33 for UNROLL=2, 17 for UNROLL=4.

## Configuration
- SHA2_SHA224_EN defined: mode is honoured; SHA-224 IV is selected and digest[31:0] is forced to 0 in SHA-224.
- SHA2_SHA224_EN undefined: mode input is ignored, only the SHA-256 IV exists, and the latched-mode register is removed.

## Test plan
- Message "abc" (single padded block, first=1, mode=0) -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid exactly 64/UNROLL+1 cycles after the handshake.
- Empty message (0x80, then zeros, length 0) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1 then first=0), driven back-to-back with blk_valid held high -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Check: second handshake at E0+64/UNROLL+2; blk_ready low throughout ROUND/FINAL.
- SHA2_SHA224_EN, "abc" with mode=1 -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, with digest[31:0]=0.
- Assert reset at round 20 of a block, then send "abc" with first=0 -> SHA-256 "abc" digest, with no digest_valid pulse from the aborted block.
- Repeat all of the above for UNROLL=1, 2 and 4 -> identical digests, with latencies of 65, 33 and 17 cycles respectively.
